keccak_rejection_sampler: RTL and testbench
===========================================

# keccak_rejection_sampler

Consumes the 64-bit word stream produced by the Keccak squeeze stage and turns it into uniformly distributed field elements mod MODULUS for the PASTA matrix/round-constant generators. Each word is masked to MOD_BITS, and out-of-range candidates are rejected. Accepted coefficients are buffered in a FIFO that can always absorb a full squeeze block. The block paces the squeeze stage through its resume handshake so the FIFO never overflows. It sits between keccak_squeeze/keccak-f1600 and the coefficient consumers.

## Interface
- MOD_BITS, 17, candidate width and coefficient width
- MODULUS, 65537, prime; candidates c with c >= MODULUS are rejected
- FIFO_DEPTH, 32, coefficient FIFO entries; must be >= WORDS_PER_BLOCK
- WORDS_PER_BLOCK, 21, words per squeeze block (rateInBytes/8; 21 for SHAKE128)
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse: load target_count, clear FIFO and counters, begin
- target_count  input  16  number of coefficients to deliver
- din  input  64  squeeze output word
- din_valid  input  1  din valid (squeeze dout_valid); no backpressure possible
- squeeze_resume  output  1  drives keccak_squeeze_resume
- coeff  output  MOD_BITS  FIFO head coefficient
- coeff_valid  output  1  FIFO non-empty
- coeff_ready  input  1  consumer pops head when coeff_valid & coeff_ready
- busy  output  1  high in REQUEST or RECEIVE
- done  output  1  all target_count coefficients popped; held until next start

## Operation
- Candidate c = din[MOD_BITS-1:0]; the upper bits are discarded. Accept iff c < MODULUS and accepted_cnt < target_count.
- FSM states: IDLE, REQUEST, RECEIVE, DONE.
- IDLE: start with target_count==0 -> DONE. start with nonzero -> REQUEST.
- REQUEST: squeeze_resume=1 only while free entries >= WORDS_PER_BLOCK and accepted_cnt < target_count. The signal is held level, not pulsed, so it is not lost while squeeze is still permuting. The first din_valid moves the state to RECEIVE; that word is processed normally.
- RECEIVE: squeeze_resume=0. Count din_valid words in word_cnt. After WORDS_PER_BLOCK words: if accepted_cnt < target_count -> REQUEST, else remain in RECEIVE. Remaining words are ignored.
- Completion: popped_cnt == target_count -> DONE, from any of REQUEST/RECEIVE.
- start in any state restarts: FIFO and all counters cleared, same transitions as from IDLE.
- din_valid in IDLE or DONE is ignored.
- Counters are 16-bit (accepted_cnt, popped_cnt) and 5-bit word_cnt; none wraps, because accepts are gated by target_count.
- FIFO: circular buffer with ptr width clog2(FIFO_DEPTH) and a separate occupancy counter.
  - Push and pop in the same cycle leave occupancy unchanged; this is legal when full or empty-with-push.
  - Pop on empty is ignored.
- The REQUEST gating rule guarantees no overflow. A push while full is a design error; the bench asserts it never happens.

## Timing
- Reset values: squeeze_resume=0, coeff=0, coeff_valid=0, busy=0, done=0; FSM=IDLE; FIFO empty.
- start at edge N -> busy=1 and squeeze_resume=1 after edge N (FIFO empty, so free entries >= block).
- Accepted din at edge N -> coeff_valid=1 after edge N (1-cycle latency, registered FIFO storage).
- Pop at edge N -> next head, or coeff_valid=0, after edge N.
- Sustained throughput: 1 word/cycle in; at most 1 coefficient/cycle out.
- Final pop at edge N -> done=1 and busy=0 after edge N.
- rst_n low mid-operation -> all outputs return to reset values immediately (asynchronous). In-flight words are lost; the squeeze stage must be reset alongside.

## Configuration
- NONZERO_REJECT_EN defined: c==0 is also rejected; this is used for invertible/nonzero matrix elements.
- NONZERO_REJECT_EN undefined: 0 is a valid coefficient.

## Test plan
- Range boundaries:
  - Stimulus: start, target_count=3; words with low 17 bits 0x10000, 0x10001, 0x1FFFF, 0x00005 (din=0xFFFFFFFFFFFE0005).
  - Required: coeffs 65536, 5 out in order; the third accept comes from the next block. squeeze_resume is re-raised after 21 words; done after 3 pops.
- Zero candidate:
  - Stimulus: din low bits 0x00000.
  - Required: accepted without NONZERO_REJECT_EN; rejected, no push, with it.
- Backpressure:
  - Stimulus: target_count=40, coeff_ready=0, all candidates valid.
  - Required: FIFO reaches 21, squeeze_resume stays 0 (free=11 < 21), no overflow. Raising coeff_ready drains it, squeeze_resume returns, 40 delivered.
- Simultaneous push/pop:
  - Stimulus: coeff_ready=1 continuously with din_valid every cycle.
  - Required: occupancy stays 1, one coefficient per cycle, order preserved.
- Zero target and restart:
  - Stimulus: start with target_count=0.
  - Required: done=1 next cycle and squeeze_resume never asserted.
  - Stimulus: start mid-RECEIVE.
  - Required: FIFO cleared, counters reset, new run correct.
- Async reset:
  - Stimulus: rst_n pulsed low mid-block.
  - Required: all outputs 0 without waiting for clk; FSM in IDLE afterwards.

Source files
------------

// File: rtl/keccak_rejection_sampler.sv
// ============================================================================
// Module   : keccak_rejection_sampler
// Brief    : Turns the 64-bit Keccak squeeze word stream into uniform field
//            elements mod MODULUS. Each word is masked to MOD_BITS. Candidates
//            that are out of range are rejected. Accepted coefficients go into
//            a FIFO, and the squeeze stage is paced so that FIFO never
//            overflows.
// Options  : NONZERO_REJECT_EN - also reject the zero candidate.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keccak_rejection_sampler #(
  parameter int MOD_BITS        = 17,
  parameter int MODULUS         = 65537,
  parameter int FIFO_DEPTH      = 32,   // must be >= WORDS_PER_BLOCK
  parameter int WORDS_PER_BLOCK = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         target_count,
  input  logic [63:0]         din,
  input  logic                din_valid,
  output logic                squeeze_resume,
  output logic [MOD_BITS-1:0] coeff,
  output logic                coeff_valid,
  input  logic                coeff_ready,
  output logic                busy,
  output logic                done
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WCNT_W = $clog2(WORDS_PER_BLOCK + 1);

  localparam logic [OCC_W-1:0]    C_DEPTH   = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]    C_BLOCK   = OCC_W'(WORDS_PER_BLOCK);
  localparam logic [WCNT_W-1:0]   C_WPB     = WCNT_W'(WORDS_PER_BLOCK);
  localparam logic [PTR_W-1:0]    C_LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [MOD_BITS:0]   C_MODULUS = (MOD_BITS + 1)'(MODULUS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RECEIVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [15:0]         r_target;
  logic [15:0]         r_acc_cnt;
  logic [15:0]         r_pop_cnt;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic [OCC_W-1:0]    r_occ;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [MOD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic                r_resume;
  logic                r_busy;
  logic                r_done;

  logic [MOD_BITS-1:0] w_cand;
  logic                w_cand_ok;
  logic                w_active;
  logic                w_word_take;
  logic                w_push;
  logic                w_pop;
  logic [WCNT_W-1:0]   w_word_inc;
  logic [15:0]         w_acc_nxt;
  logic [15:0]         w_pop_nxt;
  logic [OCC_W-1:0]    w_occ_nxt;
  logic [15:0]         w_target_nxt;
  logic                w_want;
  logic                w_unused;

  // Only the low MOD_BITS of each squeeze word are ever used.
  assign w_unused = &{1'b0, din[63:MOD_BITS]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Candidate screening, FIFO push/pop decisions and next counter values.
  always_comb begin
    w_cand    = din[MOD_BITS-1:0];
    w_cand_ok = ({1'b0, w_cand} < C_MODULUS);
`ifdef NONZERO_REJECT_EN
    w_cand_ok = w_cand_ok && (w_cand != '0);
`endif
    w_active    = (r_state == ST_REQUEST) || (r_state == ST_RECEIVE);
    // A saturated word counter means the final block is over; the tail of
    // that block is dropped.
    w_word_take = !start && din_valid && w_active && (r_word_cnt != C_WPB);
    w_push      = w_word_take && w_cand_ok && (r_acc_cnt < r_target);
    w_pop       = !start && coeff_valid && coeff_ready;
    w_word_inc  = r_word_cnt + WCNT_W'(1);
    if (start) begin
      w_acc_nxt = '0;
      w_pop_nxt = '0;
      w_occ_nxt = '0;
    end else begin
      w_acc_nxt = r_acc_cnt + {15'd0, w_push};
      w_pop_nxt = r_pop_cnt + {15'd0, w_pop};
      w_occ_nxt = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
    w_target_nxt = start ? target_count : r_target;
    // Ask for another block only if it can land in the FIFO completely.
    w_want = ((C_DEPTH - w_occ_nxt) >= C_BLOCK) && (w_acc_nxt < w_target_nxt);
  end

  // FIFO pointers, occupancy and the accept/pop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_acc_cnt <= '0;
      r_pop_cnt <= '0;
    end else if (start) begin
      r_occ     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_acc_cnt <= '0;
      r_pop_cnt <= '0;
    end else begin
      r_occ     <= w_occ_nxt;
      r_acc_cnt <= w_acc_nxt;
      r_pop_cnt <= w_pop_nxt;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Coefficient storage; validity is tracked by occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_cand;
  end

  // Control FSM with registered resume/busy/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_word_cnt <= '0;
      r_resume   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (start) begin
      r_target   <= target_count;
      r_word_cnt <= '0;
      if (target_count == 16'd0) begin
        r_state  <= ST_DONE;
        r_resume <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        r_state  <= ST_REQUEST;
        r_resume <= w_want;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_REQUEST, ST_RECEIVE: begin
          if (w_pop_nxt == r_target) begin
            r_state  <= ST_DONE;
            r_resume <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (w_word_take) begin
            if ((w_word_inc == C_WPB) && (w_acc_nxt < r_target)) begin
              r_state    <= ST_REQUEST;
              r_word_cnt <= '0;
              r_resume   <= w_want;
            end else begin
              // Also the terminal case: counter saturates at the block size.
              r_state    <= ST_RECEIVE;
              r_word_cnt <= w_word_inc;
              r_resume   <= 1'b0;
            end
          end else begin
            // Held level while waiting so a permuting squeeze cannot miss it.
            r_resume <= (r_state == ST_REQUEST) && w_want;
          end
        end
        default: begin
          r_resume <= 1'b0;
        end
      endcase
    end
  end

  assign squeeze_resume = r_resume;
  assign busy           = r_busy;
  assign done           = r_done;
  assign coeff_valid    = (r_occ != '0);
  assign coeff          = coeff_valid ? r_mem[r_rptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_keccak_rejection_sampler.sv
// ============================================================================
// Module   : tb_keccak_rejection_sampler
// Brief    : Scoreboard bench for keccak_rejection_sampler. A squeeze-stage
//            model answers squeeze_resume with blocks of words. A reference
//            model queues the expected coefficients, and a monitor compares
//            every pop against them.
// Options  : NONZERO_REJECT_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keccak_rejection_sampler;

  localparam int MOD_BITS   = 17;
  localparam int MODULUS    = 65537;
  localparam int FIFO_DEPTH = 32;
  localparam int WPB        = 21;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target_count = '0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        coeff_ready = 1'b0;
  logic        squeeze_resume;
  logic [16:0] coeff;
  logic        coeff_valid;
  logic        busy;
  logic        done;

  keccak_rejection_sampler #(
    .MOD_BITS(MOD_BITS), .MODULUS(MODULUS),
    .FIFO_DEPTH(FIFO_DEPTH), .WORDS_PER_BLOCK(WPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_count(target_count),
    .din(din), .din_valid(din_valid), .squeeze_resume(squeeze_resume),
    .coeff(coeff), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] popped_log[$];
  logic [63:0] word_q[$];
  int          m_target = 0, m_acc = 0, m_popped = 0, max_occ = 0;
  int          blocks_started = 0;
  bit          sq_en = 0, sq_busy = 0, sq_gaps = 0, mon_en = 0, rand_ready = 0;
  int          gen_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cand_ok(input logic [16:0] c);
`ifdef NONZERO_REJECT_EN
    return (int'(c) < MODULUS) && (c != 17'd0);
`else
    return int'(c) < MODULUS;
`endif
  endfunction

  // Reference model: a word becomes a coefficient iff it is in range and
  // the run still needs coefficients.
  task automatic model_word(input logic [63:0] w);
    logic [16:0] c;
    c = w[16:0];
    if (cand_ok(c) && (m_acc < m_target)) begin
      exp_q.push_back(c);
      m_acc++;
    end
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
    check("no_overflow", exp_q.size() <= FIFO_DEPTH, 1'b1);
  endtask

  function automatic logic [63:0] next_word();
    logic [63:0] w;
    logic [16:0] c;
    int          r;
    if (word_q.size() != 0) return word_q.pop_front();
    w = {$urandom, $urandom};
    if (gen_mode == 1) begin
      c = 17'($urandom_range(1, MODULUS - 1));
    end else begin
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1:    c = 17'($urandom_range(MODULUS, 131071));
        2:       c = 17'd0;
        3:       c = 17'(MODULUS - 1);
        4:       c = 17'(MODULUS);
        default: c = 17'($urandom_range(1, MODULUS - 1));
      endcase
    end
    w[16:0] = c;
    return w;
  endfunction

  // Squeeze-stage model: after seeing resume, a short permutation delay, then
  // one block of WPB words.
  initial begin
    forever begin
      @(posedge clk); #1;
      din_valid = 1'b0;
      if (sq_en && rst_n && squeeze_resume) begin
        sq_busy = 1;
        blocks_started++;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        for (int i = 0; i < WPB; i++) begin
          if (!sq_en || !rst_n) break;
          if (sq_gaps) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          if (!sq_en || !rst_n) break;
          din = next_word();
          din_valid = 1'b1;
          @(posedge clk);
          if (!start && rst_n) model_word(din);
          #1 din_valid = 1'b0;
        end
        sq_busy = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) coeff_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every DUT pop and checks pacing.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        check("coeff_valid", coeff_valid, exp_q.size() != 0);
        if (squeeze_resume) begin
          check("resume_room", (FIFO_DEPTH - exp_q.size()) >= WPB, 1'b1);
          check("resume_need", m_acc < m_target, 1'b1);
        end
        if (coeff_valid && coeff_ready && exp_q.size() != 0) begin
          check("coeff_data", coeff, exp_q[0]);
          popped_log.push_back(coeff);
          void'(exp_q.pop_front());
          m_popped++;
        end
      end
    end
  end

  task automatic do_start(input int tc);
    int k;
    sq_en = 0;
    k = 0;
    while (sq_busy && k < 100) begin @(posedge clk); k++; end
    check("squeeze_idle", sq_busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    target_count = 16'(tc);
    @(posedge clk);
    exp_q.delete();
    popped_log.delete();
    m_acc = 0; m_popped = 0; m_target = tc; max_occ = 0; blocks_started = 0;
    sq_en = 1;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (m_popped < m_target && k < 5000) begin @(negedge clk); k++; end
    check({nm, "_complete"}, k < 5000, 1'b1);
    @(negedge clk);
    check({nm, "_done"}, done, 1'b1);
    check({nm, "_busy"}, busy, 1'b0);
    check({nm, "_resume"}, squeeze_resume, 1'b0);
    check({nm, "_count"}, popped_log.size(), m_target);
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k;
    k = 0;
    while (m_acc < n && k < 2000) begin @(negedge clk); k++; end
    check(nm, m_acc >= n, 1'b1);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_resume"}, squeeze_resume, 1'b0);
    check({nm, "_coeff"}, coeff, 17'd0);
    check({nm, "_valid"}, coeff_valid, 1'b0);
    check({nm, "_busy"}, busy, 1'b0);
    check({nm, "_done"}, done, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");
    mon_en = 1;

    // Range boundaries: 65536 accepted, 65537 and 0x1FFFF rejected.
    coeff_ready = 1'b1; sq_gaps = 0; gen_mode = 1;
    word_q.push_back(64'hDEAD_BEEF_0001_0000);
    word_q.push_back(64'h1234_5678_9AB1_0001);
    word_q.push_back(64'h0F0F_0F0F_F0F1_FFFF);
    word_q.push_back(64'hFFFF_FFFF_FFFE_0005);
    for (int i = 0; i < WPB - 4; i++) word_q.push_back(64'hFFFF_0000_0003_FFFF);
    do_start(3);
    @(negedge clk);
    check("start_busy", busy, 1'b1);
    check("start_resume", squeeze_resume, 1'b1);
    wait_done("range");
    check("range_c0", popped_log[0], 17'd65536);
    check("range_c1", popped_log[1], 17'd5);
    check("range_blocks", blocks_started, 2);

    // Zero candidate.
    word_q.push_back(64'hAAAA_5555_0000_0000);
    word_q.push_back(64'hAAAA_5555_0000_0007);
    word_q.push_back(64'h1234_0000_00F0_0000);
    word_q.push_back(64'hAAAA_5555_0000_0009);
    do_start(4);
    wait_done("zero");
`ifdef NONZERO_REJECT_EN
    check("zero_c0", popped_log[0], 17'd7);
    check("zero_c1", popped_log[1], 17'd9);
`else
    check("zero_c0", popped_log[0], 17'd0);
    check("zero_c1", popped_log[1], 17'd7);
    check("zero_c2", popped_log[2], 17'd0);
`endif

    // Backpressure: one block fills 21 entries, no room for another.
    coeff_ready = 1'b0; gen_mode = 1;
    do_start(40);
    wait_acc(21, "bp_fill");
    repeat (10) begin
      @(negedge clk);
      check("bp_resume_low", squeeze_resume, 1'b0);
    end
    check("bp_occupancy", exp_q.size(), 21);
    check("bp_valid", coeff_valid, 1'b1);
    check("bp_busy", busy, 1'b1);
    @(posedge clk); #1 coeff_ready = 1'b1;
    wait_done("bp");
    check("bp_blocks", blocks_started, 2);

    // Simultaneous push/pop at one word per cycle.
    coeff_ready = 1'b1; gen_mode = 1; sq_gaps = 0;
    do_start(60);
    wait_done("stream");
    check("stream_occupancy", max_occ <= 1, 1'b1);

    // Zero target.
    do_start(0);
    @(negedge clk);
    check("zt_done", done, 1'b1);
    check("zt_busy", busy, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("zt_resume", squeeze_resume, 1'b0);
    end
    @(posedge clk); #1;

    // Restart in the middle of a block.
    coeff_ready = 1'b0; gen_mode = 1; sq_gaps = 1;
    do_start(30);
    wait_acc(5, "rs_fill");
    check("rs_busy_mid", busy, 1'b1);
    check("rs_resume_mid", squeeze_resume, 1'b0);
    @(posedge clk); #1;
    do_start(7);
    @(negedge clk);
    check("rs_cleared", coeff_valid, 1'b0);
    check("rs_busy", busy, 1'b1);
    check("rs_done", done, 1'b0);
    @(posedge clk); #1 coeff_ready = 1'b1;
    wait_done("restart");

    // Asynchronous reset mid-block.
    gen_mode = 0; sq_gaps = 0;
    do_start(50);
    wait_acc(3, "ar_fill");
    @(posedge clk); #3;
    mon_en = 0; sq_en = 0;
    rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    exp_q.delete(); m_acc = 0; m_popped = 0; m_target = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check_outputs_zero("after_reset");
    @(posedge clk); #1;
    do_start(5);
    wait_done("post_reset_run");

    // Randomised runs with a jittery consumer.
    rand_ready = 1; sq_gaps = 1; gen_mode = 0;
    for (int r = 0; r < 4; r++) begin
      do_start(int'($urandom_range(1, 60)));
      wait_done("random");
    end
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
